// File: rtl/mode1_fetch_pkg.sv
// rtl/mode1_fetch_pkg.sv - shared widths, latency and FSM encoding for the mode1 fetch sequencer
package mode1_fetch_pkg;

  localparam int DATAWIDTH = 16;
  localparam int AWIDTH    = 8;
  localparam int PIPE_LAT  = 3;

  // One extra bit so a full 2^AWIDTH-line vector is representable
  localparam int CNTW      = AWIDTH + 1;
  localparam int DRAINW    = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mode1_fetch.sv
// rtl/mode1_fetch.sv - streams N SRAM lines into the mode1 max tree and latches the vector max
module mode1_fetch
  import mode1_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [AWIDTH-1:0]      start_addr,
  input  logic [AWIDTH-1:0]      end_addr,
  output logic [AWIDTH-1:0]      mem_addr,
  output logic                   mem_rd_en,
  input  logic [4*DATAWIDTH-1:0] mem_rdata,
  output logic [DATAWIDTH-1:0]   inp0,
  output logic [DATAWIDTH-1:0]   inp1,
  output logic [DATAWIDTH-1:0]   inp2,
  output logic [DATAWIDTH-1:0]   inp3,
  output logic                   mode1_run,
  output logic                   max_clr,
  input  logic [DATAWIDTH-1:0]   max_in,
  output logic [DATAWIDTH-1:0]   max_out,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_e                 state_q, state_d;
  logic [AWIDTH-1:0]      mem_addr_q, mem_addr_d;
  logic [CNTW-1:0]        rem_q, rem_d;
  logic [DRAINW-1:0]      drain_q, drain_d;
  logic                   rd_en_q, rd_en_d;
  logic                   run_q, run_d;
  logic                   clr_q, clr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [DATAWIDTH-1:0]   max_out_q, max_out_d;

  // Next-state and next-output logic; pulse outputs default low every cycle
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    rem_d      = rem_q;
    drain_d    = drain_q;
    rd_en_d    = rd_en_q;
    run_d      = rd_en_q;
    clr_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    max_out_d  = max_out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (end_addr >= start_addr) begin
            state_d    = ST_FETCH;
            mem_addr_d = start_addr;
            rem_d      = CNTW'(end_addr) - CNTW'(start_addr) + CNTW'(1);
            rd_en_d    = 1'b1;
            clr_d      = 1'b1;
            busy_d     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        // rem_q counts reads still to issue, including the one in this cycle
        if (rem_q == CNTW'(1)) begin
          rd_en_d = 1'b0;
          rem_d   = '0;
          drain_d = '0;
          state_d = ST_DRAIN;
        end else begin
          mem_addr_d = mem_addr_q + AWIDTH'(1);
          rem_d      = rem_q - CNTW'(1);
        end
      end
      ST_DRAIN: begin
        // The first DRAIN cycle carries the last mode1_run; the tree result settles PIPE_LAT later
        if (drain_q == DRAINW'(PIPE_LAT)) begin
          max_out_d = max_in;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end else begin
          drain_d = drain_q + DRAINW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset clears everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      rem_q      <= '0;
      drain_q    <= '0;
      rd_en_q    <= 1'b0;
      run_q      <= 1'b0;
      clr_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      max_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      rem_q      <= rem_d;
      drain_q    <= drain_d;
      rd_en_q    <= rd_en_d;
      run_q      <= run_d;
      clr_q      <= clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      max_out_q  <= max_out_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd_en = rd_en_q;
  assign mode1_run = run_q;
  assign max_clr   = clr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign max_out   = max_out_q;

  assign inp0 = mem_rdata[0*DATAWIDTH +: DATAWIDTH];
  assign inp1 = mem_rdata[1*DATAWIDTH +: DATAWIDTH];
  assign inp2 = mem_rdata[2*DATAWIDTH +: DATAWIDTH];
  assign inp3 = mem_rdata[3*DATAWIDTH +: DATAWIDTH];

endmodule

// File: tb/tb_mode1_fetch.sv
// tb/tb_mode1_fetch.sv - self-checking bench with SRAM and max-tree models for mode1_fetch
module tb_mode1_fetch;
  import mode1_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  start_addr, end_addr, mem_addr;
  logic        mem_rd_en;
  logic [63:0] mem_rdata = '0;
  logic [15:0] inp0, inp1, inp2, inp3, max_in, max_out;
  logic        mode1_run, max_clr, busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mode1_fetch dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .end_addr(end_addr),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .inp0(inp0), .inp1(inp1), .inp2(inp2), .inp3(inp3),
    .mode1_run(mode1_run), .max_clr(max_clr), .max_in(max_in), .max_out(max_out),
    .busy(busy), .done(done), .err(err)
  );

  // fp16 total order for finite values: map to an unsigned key
  function automatic logic [15:0] fkey(input logic [15:0] x);
    return x[15] ? ~x : (x | 16'h8000);
  endfunction

  function automatic bit fgt(input logic [15:0] a, input logic [15:0] b);
    return fkey(a) > fkey(b);
  endfunction

  function automatic logic [15:0] lane_max4(input logic [63:0] line);
    logic [15:0] best;
    best = line[15:0];
    for (int k = 1; k < 4; k++)
      if (fgt(line[k*16 +: 16], best)) best = line[k*16 +: 16];
    return best;
  endfunction

  // 1-cycle SRAM
  logic [63:0] mem [256];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  // mode1 max tree: result of a mode1_run cycle visible on max_in PIPE_LAT cycles later
  logic [15:0] s1, s2, acc;
  logic        v1, v2, accv;
  always @(posedge clk) begin
    if (reset || max_clr) begin
      v1 <= 1'b0; v2 <= 1'b0; accv <= 1'b0; acc <= '0; s1 <= '0; s2 <= '0;
    end else begin
      v1 <= mode1_run;
      s1 <= lane_max4({inp3, inp2, inp1, inp0});
      v2 <= v1;
      s2 <= s1;
      if (v2) begin
        acc  <= (!accv || fgt(s2, acc)) ? s2 : acc;
        accv <= 1'b1;
      end
    end
  end
  assign max_in = acc;

  // Reference: max over every lane of every line in the inclusive range
  function automatic logic [15:0] model_max(input logic [7:0] sa, input logic [7:0] ea);
    logic [15:0] best;
    best = mem[sa][15:0];
    for (int a = int'(sa); a <= int'(ea); a++)
      for (int k = 0; k < 4; k++)
        if (fgt(mem[a][k*16 +: 16], best)) best = mem[a][k*16 +: 16];
    return best;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int r_done_cyc, r_done_cnt, r_err_cyc, r_err_cnt, r_rd_cnt, r_addr_bad;
  int r_run_cnt, r_run_bad, r_lane_bad, r_clr_cnt, r_clr_cyc, r_busy_cnt;
  logic [15:0] r_mout;
  logic [7:0]  r_last_addr;
  logic [15:0] exp_max_out = '0;

  // Drive one start in the current cycle (cycle 0) and record what the DUT does
  task automatic run_vec(input logic [7:0] sa, input logic [7:0] ea, input int r0, input int r1,
                         input int r2, input int gap, input int budget);
    logic [7:0] exp_addr;
    r_done_cyc = -1; r_done_cnt = 0; r_err_cyc = -1; r_err_cnt = 0; r_rd_cnt = 0;
    r_addr_bad = 0; r_run_cnt = 0; r_run_bad = 0; r_lane_bad = 0; r_clr_cnt = 0;
    r_clr_cyc = -1; r_busy_cnt = 0; r_mout = '0; r_last_addr = '0;
    start_addr = sa; end_addr = ea; start = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      tick();
      start      = (cyc == r0) || (cyc == r1) || (cyc == r2);
      start_addr = 8'($urandom);
      end_addr   = 8'($urandom);
      if (mem_rd_en) begin
        r_rd_cnt++;
        exp_addr = sa + 8'(r_rd_cnt - 1);
        if (mem_addr !== exp_addr || cyc != r_rd_cnt) r_addr_bad++;
      end
      if (mode1_run) begin
        r_run_cnt++;
        if (cyc != r_run_cnt + 1) r_run_bad++;
        if ({inp3, inp2, inp1, inp0} !== mem[sa + 8'(r_run_cnt - 1)]) r_lane_bad++;
      end
      if (max_clr) begin r_clr_cnt++; r_clr_cyc = cyc; end
      if (err) begin r_err_cnt++; r_err_cyc = cyc; end
      if (busy) r_busy_cnt++;
      if (done) begin
        r_done_cnt++;
        if (r_done_cyc < 0) begin r_done_cyc = cyc; r_mout = max_out; end
      end
      r_last_addr = mem_addr;
      if (r_done_cyc >= 0 && cyc >= r_done_cyc + gap) break;
    end
    start = 1'b0;
  endtask

  task automatic eval_vec(input int id, input logic [7:0] sa, input logic [7:0] ea,
                          input int exp_done_tab, input logic [15:0] exp_max_tab, input bit has_max);
    int n;
    logic [15:0] m;
    if (ea >= sa) begin
      n = int'(ea) - int'(sa) + 1;
      m = has_max ? exp_max_tab : model_max(sa, ea);
      check($sformatf("v%0d_done_cyc", id), r_done_cyc, n + 5);
      if (exp_done_tab >= 0) check($sformatf("v%0d_done_tab", id), r_done_cyc, exp_done_tab);
      check($sformatf("v%0d_done_cnt", id), r_done_cnt, 1);
      check($sformatf("v%0d_rd_cnt", id), r_rd_cnt, n);
      check($sformatf("v%0d_addr_bad", id), r_addr_bad, 0);
      check($sformatf("v%0d_run_cnt", id), r_run_cnt, n);
      check($sformatf("v%0d_run_bad", id), r_run_bad, 0);
      check($sformatf("v%0d_lane_bad", id), r_lane_bad, 0);
      check($sformatf("v%0d_clr_cnt", id), r_clr_cnt, 1);
      check($sformatf("v%0d_clr_cyc", id), r_clr_cyc, 1);
      check($sformatf("v%0d_err_cnt", id), r_err_cnt, 0);
      check($sformatf("v%0d_busy_cnt", id), r_busy_cnt, n + 4);
      check($sformatf("v%0d_max_out", id), r_mout, m);
      check($sformatf("v%0d_addr_hold", id), r_last_addr, ea);
      exp_max_out = m;
    end else begin
      check($sformatf("v%0d_err_cnt", id), r_err_cnt, 1);
      check($sformatf("v%0d_err_cyc", id), r_err_cyc, 1);
      check($sformatf("v%0d_rd_cnt", id), r_rd_cnt, 0);
      check($sformatf("v%0d_busy_cnt", id), r_busy_cnt, 0);
      check($sformatf("v%0d_done_cnt", id), r_done_cnt, 0);
      check($sformatf("v%0d_clr_cnt", id), r_clr_cnt, 0);
      check($sformatf("v%0d_max_keep", id), max_out, exp_max_out);
    end
  endtask

  typedef struct {
    logic [7:0]  sa;
    logic [7:0]  ea;
    int          r0, r1, r2;
    int          gap;
    int          budget;
    int          exp_done;
    logic [15:0] exp_max;
    bit          has_max;
  } vec_t;

  vec_t tab [7];

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_rd_en"}, mem_rd_en, 0);
    check({tag, "_run"}, mode1_run, 0);
    check({tag, "_clr"}, max_clr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_max_out"}, max_out, 0);
  endtask

  initial begin
    int seen_done, seen_busy;
    logic [7:0] sa, ea;
    int n;

    // Background lines all below 1.0 in magnitude so directed maxima dominate
    for (int a = 0; a < 256; a++)
      for (int k = 0; k < 4; k++)
        mem[a][k*16 +: 16] = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 14)), 10'($urandom)};
    mem[5]  = {16'h3800, 16'hC000, 16'h4200, 16'h3C00};
    mem[2]  = {16'h3C00, 16'hC400, 16'h4780, 16'h4000};
    mem[21] = {16'h4880, 16'h3C00, 16'hC800, 16'h4400};
    mem[30] = {16'h3400, 16'h4000, 16'hBC00, 16'h3C00};

    tab[0] = '{8'd5,  8'd5,   -1, -1, -1, 1, 20,  6,   16'h4200, 1'b1};
    tab[1] = '{8'd0,  8'd3,   -1, -1, -1, 1, 20,  9,   16'h4780, 1'b1};
    tab[2] = '{8'd20, 8'd22,  -1, -1, -1, 1, 20,  8,   16'h4880, 1'b1};
    tab[3] = '{8'd30, 8'd31,  -1, -1, -1, 1, 20,  7,   16'h4000, 1'b1};
    tab[4] = '{8'd10, 8'd4,   -1, -1, -1, 1, 6,   -1,  16'h0000, 1'b0};
    tab[5] = '{8'd40, 8'd47,  3,  10, 13, 3, 30,  13,  16'h0000, 1'b0};
    tab[6] = '{8'd0,  8'd255, -1, -1, -1, 1, 280, 261, 16'h4880, 1'b1};

    reset = 1'b1; start = 1'b0; start_addr = '0; end_addr = '0;
    repeat (3) tick();
    check_all_zero("rst");
    reset = 1'b0;
    tick();

    // Vectors 2 and 3 run back to back: B starts the cycle after A's done
    for (int i = 0; i < 7; i++) begin
      run_vec(tab[i].sa, tab[i].ea, tab[i].r0, tab[i].r1, tab[i].r2, tab[i].gap, tab[i].budget);
      eval_vec(i, tab[i].sa, tab[i].ea, tab[i].exp_done, tab[i].exp_max, tab[i].has_max);
      if (i != 2) tick();
    end

    for (int i = 0; i < 12; i++) begin
      sa = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        n  = int'(sa) + $urandom_range(0, 15);
        ea = (n > 255) ? 8'hFF : 8'(n);
      end else begin
        ea = 8'($urandom);
      end
      n = (ea >= sa) ? int'(ea) - int'(sa) + 1 : 0;
      run_vec(sa, ea, -1, -1, -1, 1, (n > 0) ? n + 12 : 6);
      eval_vec(100 + i, sa, ea, -1, 16'h0000, 1'b0);
      if ($urandom_range(0, 1) != 0) tick();
    end

    // Reset in cycle 3 of an 8-line vector
    start = 1'b1; start_addr = 8'd100; end_addr = 8'd107;
    tick(); start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_all_zero("midrst");
    reset = 1'b0;
    exp_max_out = '0;
    seen_done = 0; seen_busy = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done) seen_done++;
      if (busy) seen_busy++;
    end
    check("midrst_no_done", seen_done, 0);
    check("midrst_no_busy", seen_busy, 0);

    // start coinciding with reset is dropped
    reset = 1'b1; start = 1'b1; start_addr = 8'd1; end_addr = 8'd2;
    tick();
    reset = 1'b0; start = 1'b0;
    check("rststart_busy1", busy, 0);
    check("rststart_rd1", mem_rd_en, 0);
    tick();
    check("rststart_busy2", busy, 0);
    check("rststart_rd2", mem_rd_en, 0);
    check("rststart_clr2", max_clr, 0);

    run_vec(8'd5, 8'd5, -1, -1, -1, 1, 20);
    eval_vec(200, 8'd5, 8'd5, 6, 16'h4200, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
